// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: memory read bus toward the instruction memory plus the
// issued-instruction outputs and redirect controls toward decode.
interface instruction_fetch_if;
   logic [31:0] address;
   logic        read;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [15:0] itype_immediate;
   logic        active;

   modport master (
      output address, read, instr_valid, instr, instr_pc, opcode, rs, rt,
             itype_immediate, active,
      input  waitrequest, readdata, stall, redirect_valid, redirect_target
   );

   modport slave (
      input  address, read, instr_valid, instr, instr_pc, opcode, rs, rt,
             itype_immediate, active,
      output waitrequest, readdata, stall, redirect_valid, redirect_target
   );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the PC, one outstanding read, instr_valid the cycle after the transfer.
// Holds the instruction while stall=1; redirects take effect after the delay slot; target 0 halts.
module instruction_fetch #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
   input  logic                clk,
   input  logic                reset,
   instruction_fetch_if.master bus
);
   typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] instr_q;
   logic [31:0] instr_pc_q;
   logic [31:0] pending_target;
   logic        pending_redirect;
   logic        instr_valid_q;
   logic        read_c;
   logic        active_c;
   logic        xfer_done;
   logic        consume;

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      read_c    = 1'b0;
      active_c  = 1'b1;
      xfer_done = 1'b0;
      consume   = 1'b0;
      case (state)
         FETCH: begin
            // read is masked in the reset cycle so an in-flight read is dropped
            read_c    = ~reset;
            xfer_done = ~bus.waitrequest;
            if (xfer_done) state_nxt = HOLD;
         end
         HOLD: begin
            consume = instr_valid_q & ~bus.stall;
            if (consume) begin
               if (pending_redirect && (pending_target == HALT_ADDRESS)) state_nxt = HALTED;
               else                                                      state_nxt = FETCH;
            end
         end
         HALTED: active_c = reset;
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc               <= RESET_VECTOR;
         instr_q          <= 32'd0;
         instr_pc_q       <= 32'd0;
         instr_valid_q    <= 1'b0;
         pending_redirect <= 1'b0;
         pending_target   <= 32'd0;
      end else begin
         if (xfer_done) begin
            instr_q       <= bus.readdata;
            instr_pc_q    <= pc;
            instr_valid_q <= 1'b1;
         end
         if (consume) begin
            instr_valid_q <= 1'b0;
            if (pending_redirect) begin
               // this instruction was the delay slot; a branch inside it is ignored
               pc               <= pending_target;
               pending_redirect <= 1'b0;
            end else begin
               pc <= pc + 32'd4;
               if (bus.redirect_valid) begin
                  pending_redirect <= 1'b1;
                  pending_target   <= bus.redirect_target;
               end
            end
         end
      end
   end

   assign bus.address         = pc;
   assign bus.read            = read_c;
   assign bus.active          = active_c;
   assign bus.instr_valid     = instr_valid_q;
   assign bus.instr           = instr_q;
   assign bus.instr_pc        = instr_pc_q;
   assign bus.opcode          = instr_q[31:26];
   assign bus.rs              = instr_q[25:21];
   assign bus.rt              = instr_q[20:16];
   assign bus.itype_immediate = instr_q[15:0];
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then random bus/stall/redirect traffic,
// checked by a transaction-level program-order model feeding a scoreboard queue.
module tb_instruction_fetch;
   localparam logic [31:0] RV = 32'hBFC00000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   instruction_fetch_if bus();

   instruction_fetch #(.RESET_VECTOR(RV), .HALT_ADDRESS(32'h00000000)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a == RV) return 32'h3C08ABCD;
      return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
   endfunction

   assign bus.readdata = word_at(bus.address);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h required %08h", name, act, exp);
      end
   endtask

   // Program-order model: which instruction must be issued next, from consume events.
   exp_t        sbq[$];
   logic        m_pend;
   logic [31:0] m_pc;
   logic [31:0] m_tgt;
   bit          m_halted = 1'b0;
   bit          m_need_push = 1'b0;

   always @(negedge clk) begin
      #1;
      if (reset) begin
         sbq.delete();
         m_pend      = 1'b0;
         m_pc        = RV;
         m_tgt       = 32'd0;
         m_halted    = 1'b0;
         m_need_push = 1'b1;
      end else begin
         if (m_need_push) begin
            sbq.push_back('{pc: m_pc, word: word_at(m_pc)});
            m_need_push = 1'b0;
         end
         if (bus.instr_valid && !bus.stall && !m_halted) begin
            if (m_pend) begin
               m_pc   = m_tgt;
               m_pend = 1'b0;
               if (m_pc == 32'd0) m_halted = 1'b1;
               else sbq.push_back('{pc: m_pc, word: word_at(m_pc)});
            end else begin
               m_pc = m_pc + 32'd4;
               if (bus.redirect_valid) begin
                  m_pend = 1'b1;
                  m_tgt  = bus.redirect_target;
               end
               sbq.push_back('{pc: m_pc, word: word_at(m_pc)});
            end
         end
      end
   end

   // Monitor: pops one expectation per newly presented instruction.
   bit          prev_v = 1'b0;
   bit          prev_rw = 1'b0;
   bit          halt_chk = 1'b0;
   logic [31:0] prev_addr = 32'd0;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev_v   = 1'b0;
         prev_rw  = 1'b0;
         halt_chk = 1'b0;
      end else begin
         if (bus.instr_valid && !prev_v) begin
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_unexpected: got instr_pc %08h, required no instruction", bus.instr_pc);
            end else begin
               e = sbq.pop_front();
               check("sb_instr_pc", bus.instr_pc, e.pc);
               check("sb_instr", bus.instr, e.word);
               check("sb_opcode", 32'(bus.opcode), 32'(e.word[31:26]));
               check("sb_rs", 32'(bus.rs), 32'(e.word[25:21]));
               check("sb_rt", 32'(bus.rt), 32'(e.word[20:16]));
               check("sb_imm", 32'(bus.itype_immediate), 32'(e.word[15:0]));
            end
         end
         if (prev_rw) begin
            check("bus_hold_addr", bus.address, prev_addr);
            check("bus_hold_read", 32'(bus.read), 32'd1);
         end
         if (halt_chk) begin
            check("halt_active", 32'(bus.active), 32'd0);
            check("halt_read", 32'(bus.read), 32'd0);
            check("halt_valid", 32'(bus.instr_valid), 32'd0);
         end
         prev_v    = bus.instr_valid;
         prev_rw   = bus.read && bus.waitrequest;
         prev_addr = bus.address;
         halt_chk  = m_halted;
      end
   end

   task automatic wait_valid(input string tag);
      int n = 0;
      @(negedge clk);
      while (!bus.instr_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.instr_valid) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: instr_valid still 0 after %0d cycles, required 1", tag, n);
      end
   endtask

   // Present one instruction for consumption with the given redirect, checking its pc.
   task automatic issue(input logic rv, input logic [31:0] tgt, input logic [31:0] exp_pc,
                        input string tag);
      bus.stall           = 1'b0;
      bus.redirect_valid  = rv;
      bus.redirect_target = tgt;
      wait_valid(tag);
      check(tag, bus.instr_pc, exp_pc);
      @(posedge clk);
      #1;
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] snap_instr;
      logic [31:0] snap_pc;
      bus.waitrequest     = 1'b0;
      bus.stall           = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = 32'd0;
      reset               = 1'b1;

      // Reset and first zero-wait fetch
      repeat (2) @(negedge clk);
      check("reset_read", 32'(bus.read), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_instr", bus.instr, 32'd0);
      check("rst_instr_pc", bus.instr_pc, 32'd0);
      check("rst_fields", {bus.opcode, bus.rs, bus.rt, bus.itype_immediate}, 32'd0);
      check("rst_active", 32'(bus.active), 32'd1);
      check("c1_read", 32'(bus.read), 32'd1);
      check("c1_address", bus.address, RV);
      @(negedge clk);
      check("f1_valid", 32'(bus.instr_valid), 32'd1);
      check("f1_opcode", 32'(bus.opcode), 32'h0F);
      check("f1_rt", 32'(bus.rt), 32'h08);
      check("f1_imm", 32'(bus.itype_immediate), 32'hABCD);
      check("f1_instr_pc", bus.instr_pc, RV);
      @(posedge clk);
      #1 bus.waitrequest = 1'b1;
      bus.stall = 1'b1;

      // Three wait states on the second fetch
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("ws_address", bus.address, RV + 32'd4);
         check("ws_read", 32'(bus.read), 32'd1);
         check("ws_valid", 32'(bus.instr_valid), 32'd0);
      end
      @(posedge clk);
      #1 bus.waitrequest = 1'b0;
      @(negedge clk);
      check("ws_valid_late", 32'(bus.instr_valid), 32'd0);
      @(negedge clk);
      check("ws_capture_valid", 32'(bus.instr_valid), 32'd1);
      check("ws_capture_pc", bus.instr_pc, RV + 32'd4);
      snap_instr = bus.instr;
      snap_pc    = bus.instr_pc;

      // Downstream stall for five cycles
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_instr", bus.instr, snap_instr);
         check("stall_instr_pc", bus.instr_pc, snap_pc);
         check("stall_imm", 32'(bus.itype_immediate), 32'(snap_instr[15:0]));
         check("stall_read", 32'(bus.read), 32'd0);
         check("stall_valid", 32'(bus.instr_valid), 32'd1);
      end
      @(posedge clk);
      #1 bus.stall = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("stall_next_addr", bus.address, snap_pc + 32'd4);

      // Branch with delay slot; branch in the delay slot is ignored
      issue(1'b0, 32'd0, RV + 32'h08, "seq_08");
      issue(1'b0, 32'd0, RV + 32'h0C, "seq_0c");
      issue(1'b1, RV + 32'h100, RV + 32'h10, "br_at_10");
      issue(1'b1, 32'hDEAD0000, RV + 32'h14, "br_delay_slot");
      issue(1'b1, 32'h00000000, RV + 32'h100, "br_target");
      issue(1'b0, 32'd0, RV + 32'h104, "halt_delay_slot");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("halted_active", 32'(bus.active), 32'd0);
         check("halted_read", 32'(bus.read), 32'd0);
      end

      // Reset during a stalled read, with a redirect pending
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      issue(1'b1, RV + 32'h200, RV, "rst2_first");
      bus.waitrequest = 1'b1;
      @(negedge clk);
      check("rstmid_pre_addr", bus.address, RV + 32'd4);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("rstmid_read", 32'(bus.read), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      bus.waitrequest = 1'b0;
      @(negedge clk);
      check("rstmid_read_after", 32'(bus.read), 32'd1);
      check("rstmid_address", bus.address, RV);
      check("rstmid_valid", 32'(bus.instr_valid), 32'd0);
      issue(1'b0, 32'd0, RV, "rstmid_i0");
      issue(1'b0, 32'd0, RV + 32'd4, "rstmid_i1");
      issue(1'b0, 32'd0, RV + 32'd8, "rstmid_i2");

      // Sequential wrap through zero does not halt
      issue(1'b1, 32'hFFFFFFF8, RV + 32'h0C, "wrap_br");
      issue(1'b0, 32'd0, RV + 32'h10, "wrap_delay");
      issue(1'b0, 32'd0, 32'hFFFFFFF8, "wrap_f8");
      issue(1'b0, 32'd0, 32'hFFFFFFFC, "wrap_fc");
      issue(1'b0, 32'd0, 32'h00000000, "wrap_zero");
      check("wrap_active", 32'(bus.active), 32'd1);
      issue(1'b0, 32'd0, 32'h00000004, "wrap_four");

      // Random traffic, reset whenever the block halts
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk);
         #1;
         if (!bus.active || ($urandom % 600) == 0) begin
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
         end
         bus.waitrequest     = ($urandom % 3) == 0;
         bus.stall           = ($urandom % 3) == 0;
         bus.redirect_valid  = ($urandom % 4) == 0;
         bus.redirect_target = (($urandom % 12) == 0) ? 32'd0 : ($urandom & 32'hFFFFFFFC);
      end

      bus.stall          = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.waitrequest    = 1'b0;
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of sign_extension and the decoder.
- Reads instruction words from the Avalon-style memory bus, holds the current word in an instruction register, and presents its decoded fields (opcode, rs, rt, 16-bit I-type immediate) to downstream logic.
- Owns the PC and implements MIPS branch-delay-slot redirect semantics.
- Flags halt when control transfers to address 0.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDRESS, 32'h00000000, redirect target that halts the CPU.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- address  output  32  word-aligned fetch address (PC).
- read  output  1  read strobe.
- waitrequest  input  1  bus stall; the transfer completes on a cycle with read=1 and waitrequest=0.
- readdata  input  32  instruction word, valid when the transfer completes.
- stall  input  1  downstream not ready; holds the current instruction.
- redirect_valid  input  1  the instruction being consumed is a taken branch or jump.
- redirect_target  input  32  target for the redirect.
- instr_valid  output  1  instr and its fields are valid.
- instr  output  32  instruction register.
- instr_pc  output  32  address the instruction was fetched from.
- opcode  output  6  instr[31:26].
- rs  output  5  instr[25:21].
- rt  output  5  instr[20:16].
- itype_immediate  output  16  instr[15:0]; feeds sign_extension.
- active  output  1  high while the CPU is running; low once halted.

Behaviour:
- States: FETCH, HOLD, HALTED. Consume event = instr_valid & ~stall.
- Reset (synchronous, overrides everything, including an in-flight read):
  - state=FETCH, pc=RESET_VECTOR, read=0 during the reset cycle.
  - instr_valid=0, instr=0, instr_pc=0, active=1.
  - pending_redirect=0, pending_target=0.
- FETCH:
  - read=1, address=pc.
  - address and read must stay stable while waitrequest=1.
  - On ~waitrequest: instr<=readdata, instr_pc<=pc, instr_valid<=1, next state HOLD.
- HOLD:
  - read=0; instr and all fields held stable while stall=1.
  - On a consume event: instr_valid<=0 and pc is updated as follows.
    - If pending_redirect=1 (the instruction is a delay slot): pc<=pending_target, pending_redirect<=0. If pending_target==HALT_ADDRESS, go to HALTED; otherwise go to FETCH.
    - Else: pc<=pc+4, go to FETCH. If redirect_valid=1, also set pending_redirect<=1 and pending_target<=redirect_target.
- redirect_valid is sampled only on a consume event; it is ignored at all other times.
- A redirect arriving while pending_redirect=1 (branch in a delay slot) is ignored; the pending redirect wins.
- The delay-slot instruction is always fetched and issued before the redirect target.
- HALTED: read=0, active=0, instr_valid=0; the block stays here until reset.
- Timing:
  - Fetch latency: instr_valid rises on the cycle after the completing transfer.
  - With zero wait states and stall=0, throughput is one instruction per 2 cycles.
- PC arithmetic is 32-bit modulo: 32'hFFFFFFFC+4 wraps to 0. A sequential wrap to 0 does NOT halt; only a redirect to HALT_ADDRESS halts.
- Field outputs are pure slices of instr; they are 0 after reset.

Test Plan:
- Reset then no wait states: read=1 and address=BFC00000 in cycle 1. readdata=3C08ABCD gives, next cycle, instr_valid=1, opcode=0F, rt=08, itype_immediate=ABCD, instr_pc=BFC00000. The following fetch address is BFC00004.
- waitrequest held 3 cycles: address and read stay constant. instr is captured only on the 4th cycle; instr_valid stays 0 until the cycle after.
- stall=1 for 5 cycles in HOLD: instr, fields and instr_pc stay unchanged and read=0. After release, the next address is instr_pc+4.
- Branch at BFC00010 consumed with redirect_valid=1, target BFC00100: the next fetch is BFC00014 (delay slot), then BFC00100. A second redirect on the delay slot is ignored.
- Jump to 00000000 consumed: the delay slot at pc+4 is fetched and issued. After it is consumed, active=0, read=0 and the block stays HALTED.
- reset asserted mid-FETCH with waitrequest=1: the next cycle has read=0, then read=1 with address=BFC00000, instr_valid=0, pending_redirect cleared.
